// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : music_pkg
//  Purpose : Shared widths and FSM state encodings for the song reader.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package music_pkg;

   localparam int DEF_NOTE_W = 6;
   localparam int DEF_DUR_W  = 6;
   localparam int DEF_IDX_W  = 5;

   // One ROM word holds {note, duration}.
   localparam int ROM_WORD_W = DEF_NOTE_W + DEF_DUR_W;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/song_reader_if.sv
`default_nettype none
// ============================================================================
//  Module  : song_reader_if
//  Purpose : Control and note bundle between the mcu/note player and the
//            song reader.
//  Ports   : master - drives play, song, note_done; receives note outputs
//            slave  - the song reader side
//  Rev     : 1.0  initial release
// ============================================================================
interface song_reader_if
   import music_pkg::*;
#(
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int DUR_W  = DEF_DUR_W
);
   logic              play;
   logic [1:0]        song;
   logic              note_done;
   logic [NOTE_W-1:0] note;
   logic [DUR_W-1:0]  duration;
   logic              new_note;
   logic              song_done;

   modport master (
      output play, song, note_done,
      input  note, duration, new_note, song_done
   );

   modport slave (
      input  play, song, note_done,
      output note, duration, new_note, song_done
   );
endinterface
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
//  Module  : dffr
//  Purpose : W-bit D flip-flop with synchronous active-high reset to zero.
//  Ports   : clk, reset (sync, active high), d (next value), q (state)
//  Rev     : 1.0  initial release
// ============================================================================
module dffr #(
   parameter int W = 1
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic [W-1:0] d,
   output logic      [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end
endmodule
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
//  Module  : song_rom
//  Purpose : Four-song note ROM, synchronous one-cycle read.
//            Address = {song, idx}; dout = {note, duration}.
//            Contents: note     = (3*idx + 7*song + 1) mod 2^NOTE_W
//                      duration = (idx + song + 1) mod 2^DUR_W, except
//                                 song 3 / idx 5 which holds duration 0
//                                 (exercises the end-of-song marker).
//  Ports   : clk, addr (IDX_W+2 bits), dout (NOTE_W+DUR_W bits)
//  Rev     : 1.0  initial release
// ============================================================================
module song_rom #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int IDX_W  = 5
) (
   input  wire logic                    clk,
   input  wire logic [IDX_W+1:0]        addr,
   output logic      [NOTE_W+DUR_W-1:0] dout
);
   function automatic logic [NOTE_W+DUR_W-1:0] rom_word(input logic [IDX_W+1:0] a);
      int unsigned       i;
      int unsigned       s;
      logic [NOTE_W-1:0] n;
      logic [DUR_W-1:0]  d;
      i = 32'(a[IDX_W-1:0]);
      s = 32'(a[IDX_W+1:IDX_W]);
      n = NOTE_W'(i * 3 + s * 7 + 1);
      d = (s == 3 && i == 5) ? '0 : DUR_W'(i + s + 1);
      return {n, d};
   endfunction

   always_ff @(posedge clk) begin
      dout <= rom_word(addr);
   end
endmodule
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
//  Module  : song_reader
//  Purpose : Steps through the notes of the selected song, presenting each
//            {note, duration} with a one-cycle new_note pulse and waiting for
//            note_done before fetching the next one. Ends with a one-cycle
//            song_done and stays in DONE until reset.
//  Ports   : clk   - clock
//            reset - synchronous active-high reset
//            bus   - song_reader_if.slave (play, song, note_done in;
//                    note, duration, new_note, song_done out)
//  Config  : SONG_END_MARKER_EN - when defined, a ROM word with duration 0
//            ends the song instead of being played.
//  Rev     : 1.0  initial release
// ============================================================================
module song_reader
   import music_pkg::*;
#(
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int DUR_W  = DEF_DUR_W,
   parameter int IDX_W  = DEF_IDX_W
) (
   input  wire logic    clk,
   input  wire logic    reset,
   song_reader_if.slave bus
);
   state_t              state, state_next;
   logic [2:0]          state_q;
   logic [IDX_W-1:0]    idx, idx_next;
   logic [NOTE_W-1:0]   note_q, note_next;
   logic [DUR_W-1:0]    dur_q, dur_next;
   logic                new_note_q, new_note_next;
   logic                song_done_q, song_done_next;
   logic [IDX_W+1:0]    rom_addr;
   logic [NOTE_W+DUR_W-1:0] rom_dout;
   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic                end_marker;

   assign state = state_t'(state_q);

   // song is taken live; only the value present during RD matters since
   // that is the cycle whose read lands in CAP.
   assign rom_addr = {bus.song, idx};
   assign rom_note = rom_dout[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_dout[DUR_W-1:0];

`ifdef SONG_END_MARKER_EN
   assign end_marker = (rom_dur == '0);
`else
   assign end_marker = 1'b0;
`endif

   song_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .dout (rom_dout)
   );

   always_comb begin
      state_next     = state;
      idx_next       = idx;
      note_next      = note_q;
      dur_next       = dur_q;
      new_note_next  = 1'b0;
      song_done_next = 1'b0;
      case (state)
         IDLE: if (bus.play) state_next = RD;
         RD:   state_next = bus.play ? CAP : IDLE;
         CAP: begin
            if (end_marker) begin
               state_next     = DONE;
               song_done_next = 1'b1;
            end else begin
               note_next     = rom_note;
               dur_next      = rom_dur;
               new_note_next = 1'b1;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            // The first WAIT cycle coincides with new_note; a note_done there
            // belongs to the previous note and is dropped.
            if (bus.note_done && !new_note_q) begin
               if (idx == '1) begin
                  state_next     = DONE;
                  song_done_next = 1'b1;
               end else begin
                  idx_next   = idx + IDX_W'(1);
                  state_next = bus.play ? RD : IDLE;
               end
            end
         end
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   dffr #(.W(3))      u_state (.clk(clk), .reset(reset), .d(state_next),     .q(state_q));
   dffr #(.W(IDX_W))  u_idx   (.clk(clk), .reset(reset), .d(idx_next),       .q(idx));
   dffr #(.W(NOTE_W)) u_note  (.clk(clk), .reset(reset), .d(note_next),      .q(note_q));
   dffr #(.W(DUR_W))  u_dur   (.clk(clk), .reset(reset), .d(dur_next),       .q(dur_q));
   dffr #(.W(1))      u_new   (.clk(clk), .reset(reset), .d(new_note_next),  .q(new_note_q));
   dffr #(.W(1))      u_done  (.clk(clk), .reset(reset), .d(song_done_next), .q(song_done_q));

   assign bus.note      = note_q;
   assign bus.duration  = dur_q;
   assign bus.new_note  = new_note_q;
   assign bus.song_done = song_done_q;
endmodule
`default_nettype wire
